// File: rtl/mic_capture_pkg.sv
// Shared constants and state type for the multi-mic I2S capture block.
// Frame geometry: 64 BCLKs per frame, left slot in bits 0..31.
package mic_capture_pkg;

    localparam int FRAME_BITS     = 64;
    localparam int SLOT_BITS      = 32;
    localparam int FIRST_DATA_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } capture_state_t;

endpackage

// File: rtl/i2s_deserializer.sv
// Per-mic MSB-first shift register for one I2S data line.
// Ports: clk_in/rst_in, strobe (sample point), window (data bit
// qualifier), data (synchronized pin), shift (collected bits).
module i2s_deserializer #(
    parameter int SAMPLE_WIDTH = 18
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    strobe,
    input  logic                    window,
    input  logic                    data,
    output logic [SAMPLE_WIDTH-1:0] shift
);

    logic [SAMPLE_WIDTH-1:0] shift_n;

    generate
        if (SAMPLE_WIDTH == 1) begin : g_one
            assign shift_n = data;
        end else begin : g_many
            assign shift_n = {shift[SAMPLE_WIDTH-2:0], data};
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift <= '0;
        end else if (strobe && window) begin
            shift <= shift_n;
        end
    end

endmodule

// File: rtl/mic_array_capture.sv
// Multi-mic I2S capture: shared BCLK/LRCL, lockstep deserializers,
// one aligned sample per mic per frame over valid/ready.
// Ports: clk_in, rst_in (sync, high), enable_in, mic_data_in,
// bclk_out, lrcl_out, sample_out/sample_valid_out/sample_ready_in,
// overrun_out (sticky), running_out.
module mic_array_capture
    import mic_capture_pkg::*;
#(
    parameter int NUM_MICS     = 3,
    parameter int BCLK_DIV     = 32,
    parameter int SAMPLE_WIDTH = 18
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             enable_in,
    input  logic [NUM_MICS-1:0]              mic_data_in,
    output logic                             bclk_out,
    output logic                             lrcl_out,
    output logic [NUM_MICS*SAMPLE_WIDTH-1:0] sample_out,
    output logic                             sample_valid_out,
    input  logic                             sample_ready_in,
    output logic                             overrun_out,
    output logic                             running_out
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_SAMP = DIV_W'(3 * BCLK_DIV / 4);
    localparam logic [5:0] BIT_LAST  = 6'(FRAME_BITS - 1);
    localparam logic [5:0] BIT_FIRST = 6'(FIRST_DATA_BIT);
    localparam logic [5:0] BIT_END   = 6'(FIRST_DATA_BIT + SAMPLE_WIDTH);
    localparam logic [5:0] BIT_SLOT  = 6'(SLOT_BITS);

    capture_state_t state, state_n;

    logic [DIV_W-1:0] div_cnt, div_n;
    logic [5:0]       bit_cnt, bit_n;
    logic             active;
    logic             frame_end;
    logic             strobe;
    logic             window;

    logic [NUM_MICS-1:0] sync1, sync2;
    logic [NUM_MICS*SAMPLE_WIDTH-1:0] shift_all;

    assign active    = (state != IDLE);
    assign frame_end = active && (div_cnt == DIV_LAST)
                       && (bit_cnt == BIT_LAST);
    assign strobe    = active && (div_cnt == DIV_SAMP);
    assign window    = (bit_cnt >= BIT_FIRST) && (bit_cnt < BIT_END);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (enable_in) state_n = RUN;
            RUN:   if (!enable_in) state_n = DRAIN;
            DRAIN: begin
                if (enable_in) state_n = RUN;
                else if (frame_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters hold at zero in IDLE; the DRAIN exit lands on the
    // natural wrap so the clocks stop low without extra gating.
    always_comb begin
        div_n = '0;
        bit_n = '0;
        if (active) begin
            if (div_cnt == DIV_LAST) begin
                bit_n = bit_cnt + 6'd1;
            end else begin
                div_n = div_cnt + 1'b1;
                bit_n = bit_cnt;
            end
        end
    end

    // BCLK/LRCL are registered from the next count so the pins are
    // glitch-free yet track the current count exactly.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk_out    <= 1'b0;
            lrcl_out    <= 1'b0;
            running_out <= 1'b0;
            sync1       <= '0;
            sync2       <= '0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_n;
            bit_cnt     <= bit_n;
            bclk_out    <= (div_n >= DIV_HALF);
            lrcl_out    <= (bit_n >= BIT_SLOT);
            running_out <= (state_n != IDLE);
            sync1       <= mic_data_in;
            sync2       <= sync1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else if (frame_end) begin
            sample_out       <= shift_all;
            sample_valid_out <= 1'b1;
            if (sample_valid_out && !sample_ready_in) begin
                overrun_out <= 1'b1;
            end
        end else if (sample_valid_out && sample_ready_in) begin
            sample_valid_out <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < NUM_MICS; g++) begin : g_mic
            i2s_deserializer #(
                .SAMPLE_WIDTH(SAMPLE_WIDTH)
            ) u_des (
                .clk_in(clk_in),
                .rst_in(rst_in),
                .strobe(strobe),
                .window(window),
                .data  (sync2[g]),
                .shift (shift_all[g*SAMPLE_WIDTH +: SAMPLE_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mic_array_capture.sv
// Self-checking bench for mic_array_capture: default build plus a
// one-mic, minimum-divider build, driven by behavioural I2S mics.
module tb_mic_array_capture;

    localparam int NM  = 3;
    localparam int DIV = 32;
    localparam int SW  = 18;
    localparam int FR  = 64 * DIV;
    localparam int NM2  = 1;
    localparam int DIV2 = 8;
    localparam int SW2  = 24;
    localparam int FR2  = 64 * DIV2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, rdy;
    logic [NM-1:0] mic;
    logic bclk, lrcl, valid, ovr, running;
    logic [NM*SW-1:0] samp;

    logic rst2, en2, rdy2;
    logic [NM2-1:0] mic2;
    logic bclk2, lrcl2, valid2, ovr2, running2;
    logic [NM2*SW2-1:0] samp2;

    int n_chk = 0;
    int n_err = 0;

    mic_array_capture #(
        .NUM_MICS(NM), .BCLK_DIV(DIV), .SAMPLE_WIDTH(SW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en),
        .mic_data_in(mic), .bclk_out(bclk), .lrcl_out(lrcl),
        .sample_out(samp), .sample_valid_out(valid),
        .sample_ready_in(rdy), .overrun_out(ovr),
        .running_out(running)
    );

    mic_array_capture #(
        .NUM_MICS(NM2), .BCLK_DIV(DIV2), .SAMPLE_WIDTH(SW2)
    ) dut2 (
        .clk_in(clk), .rst_in(rst2), .enable_in(en2),
        .mic_data_in(mic2), .bclk_out(bclk2), .lrcl_out(lrcl2),
        .sample_out(samp2), .sample_valid_out(valid2),
        .sample_ready_in(rdy2), .overrun_out(ovr2),
        .running_out(running2)
    );

    // Mic model: learns slot position from LRCL on BCLK rise, shifts
    // the next bit out on BCLK fall (one-bit delay after LRCL edge).
    logic [NM*SW-1:0] fixed_q[$];
    logic [NM*SW-1:0] exp_q[$];
    logic [NM*SW-1:0] cur_w = '0;
    logic pb = 1'b0, plr = 1'b1;
    int   pos = 0;

    always @(negedge clk) begin
        if (rst) begin
            plr = 1'b1;
            pos = 0;
            exp_q.delete();
        end else begin
            if (!pb && bclk) begin
                if (plr && !lrcl) pos = 0;
                else pos++;
                plr = lrcl;
            end
            if (pb && !bclk) begin
                if (pos == 0) begin
                    if (fixed_q.size() > 0) begin
                        cur_w = fixed_q.pop_front();
                    end else begin
                        for (int i = 0; i < NM; i++)
                            cur_w[i*SW +: SW] = SW'($urandom);
                    end
                    exp_q.push_back(cur_w);
                end
                for (int i = 0; i < NM; i++)
                    mic[i] = (pos < SW) ? cur_w[i*SW + SW - 1 - pos]
                                        : 1'($urandom);
            end
        end
        pb = bclk;
    end

    logic [SW2-1:0] exp2_q[$];
    logic [SW2-1:0] cur2 = '0;
    logic pb2 = 1'b0, plr2 = 1'b1;
    int   pos2 = 0;

    always @(negedge clk) begin
        if (rst2) begin
            plr2 = 1'b1;
            pos2 = 0;
            exp2_q.delete();
        end else begin
            if (!pb2 && bclk2) begin
                if (plr2 && !lrcl2) pos2 = 0;
                else pos2++;
                plr2 = lrcl2;
            end
            if (pb2 && !bclk2) begin
                if (pos2 == 0) begin
                    cur2 = SW2'($urandom);
                    exp2_q.push_back(cur2);
                end
                mic2[0] = (pos2 < SW2) ? cur2[SW2 - 1 - pos2]
                                       : 1'($urandom);
            end
        end
        pb2 = bclk2;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rdy = 1'b0; mic = '0;
        step();
        step();
        n_chk++;
        if ({bclk, lrcl, valid, ovr, running} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 00000",
                     {bclk, lrcl, valid, ovr, running});
        end
        n_chk++;
        if (samp !== '0) begin
            n_err++;
            $display("FAIL reset_sample got %h want 0", samp);
        end
        rst = 1'b0;
        repeat (5) step();
        n_chk++;
        if ({bclk, running} !== 2'b0) begin
            n_err++;
            $display("FAIL idle_hold got %b want 00", {bclk, running});
        end
    endtask

    // Schedule from enable: t cycles after the enable sample edge.
    task automatic check_sched(input int t, input string tag);
        logic eb, el;
        eb = ((t % DIV) >= DIV / 2);
        el = (((t / DIV) % 64) >= 32);
        n_chk++;
        if (bclk !== eb) begin
            n_err++;
            $display("FAIL %s_bclk t=%0d got %b want %b", tag, t, bclk, eb);
        end
        n_chk++;
        if (lrcl !== el) begin
            n_err++;
            $display("FAIL %s_lrcl t=%0d got %b want %b", tag, t, lrcl, el);
        end
        n_chk++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL %s_running t=%0d got %b want 1", tag, t, running);
        end
        n_chk++;
        if (valid !== (t >= FR)) begin
            n_err++;
            $display("FAIL %s_valid t=%0d got %b want %b",
                     tag, t, valid, (t >= FR));
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [NM*SW-1:0] w;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_queue got empty want one frame", tag);
        end else begin
            w = exp_q.pop_front();
            if (samp !== w) begin
                n_err++;
                $display("FAIL %s_data got %h want %h", tag, samp, w);
            end
        end
    endtask

    task automatic test_capture();
        logic [NM*SW-1:0] want;
        want = {18'h20000, 18'h1FFFF, 18'h2A5A5};
        fixed_q.push_back(want);
        en = 1'b1;
        step();
        for (int t = 0; t <= FR; t++) begin
            if (t > 0) step();
            check_sched(t, "cap");
        end
        n_chk++;
        if (samp !== want) begin
            n_err++;
            $display("FAIL cap_fixed got %h want %h", samp, want);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_ready_at_frame_end();
        repeat (FR - 1) step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        n_chk++;
        if ({valid, ovr} !== 2'b10) begin
            n_err++;
            $display("FAIL rdy_edge got v=%b o=%b want v=1 o=0", valid, ovr);
        end
        pop_compare("rdy_edge");
    endtask

    task automatic test_overrun();
        repeat (FR - 1) step();
        n_chk++;
        if (ovr !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_before got %b want 0", ovr);
        end
        step();
        n_chk++;
        if ({valid, ovr} !== 2'b11) begin
            n_err++;
            $display("FAIL ovr_set got v=%b o=%b want 11", valid, ovr);
        end
        pop_compare("ovr");
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        n_chk++;
        if ({valid, ovr} !== 2'b01) begin
            n_err++;
            $display("FAIL consume got v=%b o=%b want 01", valid, ovr);
        end
    endtask

    task automatic test_drain();
        repeat (319) step();
        en = 1'b0;
        repeat (FR - 321) step();
        n_chk++;
        if ({running, valid} !== 2'b10) begin
            n_err++;
            $display("FAIL drain_run got r=%b v=%b want 10", running, valid);
        end
        step();
        n_chk++;
        if ({running, valid} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_end got r=%b v=%b want 01", running, valid);
        end
        pop_compare("drain");
        rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_chk++;
            if ({bclk, lrcl, running, valid} !== 4'b0) begin
                n_err++;
                $display("FAIL drain_idle i=%0d got %b want 0000",
                         i, {bclk, lrcl, running, valid});
            end
        end
        rdy = 1'b0;
    endtask

    task automatic test_redrain();
        en = 1'b1;
        step();
        for (int t = 0; t <= FR; t++) begin
            if (t > 0) step();
            check_sched(t, "redrain");
            if (t == 10 * DIV) en = 1'b0;
            if (t == 20 * DIV) en = 1'b1;
        end
        pop_compare("redrain");
    endtask

    task automatic test_reset_mid();
        repeat (700) step();
        rst = 1'b1;
        step();
        n_chk++;
        if ({bclk, lrcl, valid, ovr, running} !== 5'b0 || samp !== '0) begin
            n_err++;
            $display("FAIL midrst got %b s=%h want 00000 s=0",
                     {bclk, lrcl, valid, ovr, running}, samp);
        end
        step();
        rst = 1'b0;
        step();
        for (int t = 0; t <= FR; t++) begin
            if (t > 0) step();
            check_sched(t, "restart");
        end
        pop_compare("restart");
    endtask

    task automatic test_min_divider();
        logic [SW2-1:0] w;
        logic eb, el, ev;
        rst2 = 1'b1; en2 = 1'b0; rdy2 = 1'b1; mic2 = '0;
        step();
        step();
        n_chk++;
        if ({bclk2, lrcl2, valid2, ovr2, running2} !== 5'b0
            || samp2 !== '0) begin
            n_err++;
            $display("FAIL min_reset got %b s=%h want 0",
                     {bclk2, lrcl2, valid2, ovr2, running2}, samp2);
        end
        rst2 = 1'b0;
        en2 = 1'b1;
        step();
        for (int t = 0; t <= 4 * FR2; t++) begin
            if (t > 0) step();
            eb = ((t % DIV2) >= DIV2 / 2);
            el = (((t / DIV2) % 64) >= 32);
            ev = (t > 0) && (t % FR2 == 0);
            n_chk++;
            if ({bclk2, lrcl2, valid2, ovr2} !== {eb, el, ev, 1'b0}) begin
                n_err++;
                $display("FAIL min_sched t=%0d got %b want %b", t,
                         {bclk2, lrcl2, valid2, ovr2}, {eb, el, ev, 1'b0});
            end
            if (ev) begin
                n_chk++;
                if (exp2_q.size() == 0) begin
                    n_err++;
                    $display("FAIL min_queue got empty want one frame");
                end else begin
                    w = exp2_q.pop_front();
                    if (samp2 !== w) begin
                        n_err++;
                        $display("FAIL min_data t=%0d got %h want %h",
                                 t, samp2, w);
                    end
                end
            end
        end
    endtask

    initial begin
        rst2 = 1'b1; en2 = 1'b0; rdy2 = 1'b0; mic2 = '0;
        test_reset();
        test_capture();
        test_ready_at_frame_end();
        test_overrun();
        test_drain();
        test_redrain();
        test_reset_mid();
        test_min_divider();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
